// File: rtl/multicycle_ctrl.sv
// Multicycle processor control unit: sequences FETCH/DECODE/EXEC/MEM/WB,
// bounds every memory handshake with a wait counter, records sticky faults
// and counts retired instructions.
module multicycle_ctrl #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        alu_src,
  output logic        mem_to_reg,
  output logic [1:0]  alu_op,
  output logic [2:0]  state,
  output logic [1:0]  fault,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  // Counter wide enough to hold WAIT_LIMIT itself.
  localparam int CW = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

  state_t        state_q, state_d;
  logic [1:0]    fault_q, fault_d;
  logic [6:0]    op_q;
  logic [CW-1:0] wait_cnt;
  logic [31:0]   retired_q;
  logic          retire, waiting, legal;
  logic          is_r, is_i, is_load, is_store, is_branch;
  logic          pc_en, ir_en, reg_en, rd_en, wr_en;

  // Legality is judged on the live opcode during DECODE; everything later
  // works from the latched copy so the instruction register may change.
  assign legal = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LOAD) ||
                 (opcode == OP_STORE) || (opcode == OP_BRANCH);

  assign is_r      = (op_q == OP_R);
  assign is_i      = (op_q == OP_I);
  assign is_load   = (op_q == OP_LOAD);
  assign is_store  = (op_q == OP_STORE);
  assign is_branch = (op_q == OP_BRANCH);

  // Next-state, strobe and fault decision for the current state.
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    pc_en   = 1'b0;
    ir_en   = 1'b0;
    reg_en  = 1'b0;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    retire  = 1'b0;
    waiting = 1'b0;
    case (state_q)
      FETCH: begin
        if (imem_ready) begin
          ir_en   = 1'b1;
          pc_en   = 1'b1;
          state_d = DECODE;
        end else begin
          waiting = 1'b1;
          if (wait_cnt == LIMIT) begin
            fault_d = FAULT_TIMEOUT;
            state_d = HALT;
          end
        end
      end
      DECODE: begin
        if (legal) begin
          state_d = EXEC;
        end else begin
          fault_d = FAULT_ILLEGAL;
          state_d = HALT;
        end
      end
      EXEC: begin
        if (is_branch) begin
          pc_en   = zero;
          retire  = 1'b1;
          state_d = FETCH;
        end else if (is_load || is_store) begin
          state_d = MEM;
        end else if (is_r || is_i) begin
          state_d = WB;
        end else begin
          state_d = HALT;
        end
      end
      MEM: begin
        if (!(is_load || is_store)) begin
          state_d = HALT;
        end else begin
          rd_en = is_load;
          wr_en = is_store;
          if (dmem_ready) begin
            if (is_load) begin
              state_d = WB;
            end else begin
              retire  = 1'b1;
              state_d = FETCH;
            end
          end else begin
            waiting = 1'b1;
            if (wait_cnt == LIMIT) begin
              fault_d = FAULT_TIMEOUT;
              state_d = HALT;
            end
          end
        end
      end
      WB: begin
        reg_en  = 1'b1;
        retire  = 1'b1;
        state_d = FETCH;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = HALT;
      end
    endcase
  end

  // ALU steering is decoded from the latched opcode only.
  always_comb begin
    alu_op  = 2'b00;
    alu_src = 1'b0;
    if (is_r) begin
      alu_op = 2'b10;
    end else if (is_i) begin
      alu_op  = 2'b11;
      alu_src = 1'b1;
    end else if (is_load || is_store) begin
      alu_op  = 2'b00;
      alu_src = 1'b1;
    end else if (is_branch) begin
      alu_op = 2'b01;
    end
  end

  assign mem_to_reg = is_load;

  // Strobes are forced low while reset is held so reset cycles look idle.
  assign pc_write  = pc_en  & ~reset;
  assign ir_write  = ir_en  & ~reset;
  assign reg_write = reg_en & ~reset;
  assign mem_read  = rd_en  & ~reset;
  assign mem_write = wr_en  & ~reset;

  assign state   = state_q;
  assign fault   = fault_q;
  assign retired = retired_q;

  // State register and sticky fault code.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FETCH;
      fault_q <= FAULT_NONE;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  // Opcode latch, loaded once per instruction in DECODE.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_q <= '0;
    end else if (state_q == DECODE) begin
      op_q <= opcode;
    end
  end

  // Handshake wait counter: restarts on every state change, counts low-ready cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state_d != state_q) begin
      wait_cnt <= '0;
    end else if (waiting) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  // Retired-instruction counter, wrapping naturally at 2^32.
  always_ff @(posedge clock) begin
    if (reset) begin
      retired_q <= '0;
    end else if (retire) begin
      retired_q <= retired_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a driver walks each instruction
// through an instruction-level model and queues the expected outputs of every
// cycle; an independent monitor compares them on the falling edge.
module tb_multicycle_ctrl;

  localparam int WL = 15;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  logic        clock = 1'b0;
  logic        reset, zero, imem_ready, dmem_ready;
  logic [6:0]  opcode;
  logic        pc_write, ir_write, reg_write, mem_read, mem_write, alu_src, mem_to_reg;
  logic [1:0]  alu_op, fault;
  logic [2:0]  state;
  logic [31:0] retired;

  multicycle_ctrl #(.WAIT_LIMIT(WL)) dut (
    .clock      (clock),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .alu_src    (alu_src),
    .mem_to_reg (mem_to_reg),
    .alu_op     (alu_op),
    .state      (state),
    .fault      (fault),
    .retired    (retired)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  st;
    logic        pcw, irw, rgw, mrd, mwr;
    logic [1:0]  flt;
    logic [31:0] ret;
    bit          chk_alu;
    logic [1:0]  aop;
    logic        asrc;
    bit          chk_m2r;
    logic        m2r;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          passes = 0;
  logic [31:0] model_ret   = '0;
  logic [1:0]  model_fault = 2'b00;
  logic [6:0]  legal_ops[5] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] rop();
    return 7'($urandom);
  endfunction

  // Instruction class: 0 R, 1 I-ALU, 2 load, 3 store, 4 branch, 5 illegal.
  function automatic int cls(input logic [6:0] op);
    case (op)
      7'b0110011: return 0;
      7'b0010011: return 1;
      7'b0000011: return 2;
      7'b0100011: return 3;
      7'b1100011: return 4;
      default:    return 5;
    endcase
  endfunction

  function automatic logic [1:0] aop_of(input int c);
    case (c)
      0:       return 2'b10;
      1:       return 2'b11;
      4:       return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic string sname(input logic [2:0] s);
    case (s)
      S_FETCH:  return "fetch";
      S_DECODE: return "decode";
      S_EXEC:   return "exec";
      S_MEM:    return "mem";
      S_WB:     return "wb";
      S_HALT:   return "halt";
      default:  return "bad";
    endcase
  endfunction

  function automatic exp_t base(input logic [2:0] st);
    exp_t e;
    e.st = st; e.pcw = 1'b0; e.irw = 1'b0; e.rgw = 1'b0; e.mrd = 1'b0; e.mwr = 1'b0;
    e.flt = model_fault; e.ret = model_ret;
    e.chk_alu = 1'b0; e.aop = 2'b00; e.asrc = 1'b0;
    e.chk_m2r = 1'b0; e.m2r = 1'b0;
    return e;
  endfunction

  // Drive one cycle of inputs just after the rising edge and queue its expectation.
  task automatic applyStimulus(input bit rst, input bit ir, input bit dr, input bit z,
                               input logic [6:0] opc, input bit push, input exp_t e);
    @(posedge clock);
    #1;
    reset      = rst;
    imem_ready = ir;
    dmem_ready = dr;
    zero       = z;
    opcode     = opc;
    if (push) exp_q.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    bit ok;
    ok = (state === e.st) && (pc_write === e.pcw) && (ir_write === e.irw) &&
         (reg_write === e.rgw) && (mem_read === e.mrd) && (mem_write === e.mwr) &&
         (fault === e.flt) && (retired === e.ret);
    if (e.chk_alu) ok = ok && (alu_op === e.aop) && (alu_src === e.asrc);
    if (e.chk_m2r) ok = ok && (mem_to_reg === e.m2r);
    checks++;
    if (ok) passes++;
    else $display("[TB] FAIL %s @%0t: got st=%0d pc=%b ir=%b rw=%b mr=%b mw=%b f=%b ret=%h aop=%b src=%b m2r=%b; want st=%0d pc=%b ir=%b rw=%b mr=%b mw=%b f=%b ret=%h aop=%b src=%b m2r=%b",
                  sname(e.st), $time, state, pc_write, ir_write, reg_write, mem_read, mem_write,
                  fault, retired, alu_op, alu_src, mem_to_reg, e.st, e.pcw, e.irw, e.rgw,
                  e.mrd, e.mwr, e.flt, e.ret, e.aop, e.asrc, e.m2r);
  endtask

  // Monitor: compares whatever the driver has queued for the current cycle.
  initial begin
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  task automatic do_reset();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, rop(), 1'b0, base(S_FETCH));
    model_ret   = '0;
    model_fault = 2'b00;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, rop(), 1'b1, base(S_FETCH));
  endtask

  task automatic go_halt(input logic [1:0] code, input int n);
    model_fault = code;
    for (int k = 0; k < n; k++)
      applyStimulus(1'b0, rb(), rb(), rb(), rop(), 1'b1, base(S_HALT));
    do_reset();
  endtask

  // One instruction: f = imem wait cycles, m = dmem wait cycles (beyond WL times out),
  // abort_at >= 0 asserts reset at that MEM cycle, hl = cycles observed in HALT.
  task automatic do_instr(input logic [6:0] op, input bit z, input int f, input int m,
                          input bit preload, input int abort_at, input int hl);
    int   c;
    exp_t e;
    c = cls(op);
    for (int k = 0; k <= f && k <= WL; k++) begin
      if (preload && k == 0) model_ret = 32'hFFFF_FFFF;
      e = base(S_FETCH);
      if (k == f) begin e.pcw = 1'b1; e.irw = 1'b1; end
      applyStimulus(1'b0, k == f, rb(), rb(), op, 1'b1, e);
      if (preload && k == 0) begin
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
      end
    end
    if (f > WL) begin go_halt(2'b10, hl); return; end
    applyStimulus(1'b0, rb(), rb(), rb(), op, 1'b1, base(S_DECODE));
    if (c == 5) begin go_halt(2'b01, hl); return; end
    e = base(S_EXEC);
    e.chk_alu = 1'b1; e.aop = aop_of(c); e.asrc = (c >= 1 && c <= 3);
    if (c == 4) e.pcw = z;
    applyStimulus(1'b0, rb(), rb(), (c == 4) ? z : rb(), rop(), 1'b1, e);
    if (c == 4) begin model_ret = model_ret + 32'd1; return; end
    if (c == 2 || c == 3) begin
      for (int k = 0; k <= m && k <= WL; k++) begin
        if (abort_at >= 0 && k == abort_at) begin do_reset(); return; end
        e = base(S_MEM);
        e.mrd = (c == 2); e.mwr = (c == 3);
        e.chk_alu = 1'b1; e.aop = 2'b00; e.asrc = 1'b1;
        applyStimulus(1'b0, rb(), k == m, rb(), rop(), 1'b1, e);
      end
      if (m > WL) begin go_halt(2'b10, hl); return; end
      if (c == 3) begin model_ret = model_ret + 32'd1; return; end
    end
    e = base(S_WB);
    e.rgw = 1'b1; e.chk_m2r = 1'b1; e.m2r = (c == 2);
    e.chk_alu = 1'b1; e.aop = aop_of(c); e.asrc = (c >= 1 && c <= 3);
    applyStimulus(1'b0, rb(), rb(), rb(), rop(), 1'b1, e);
    model_ret = model_ret + 32'd1;
  endtask

  initial begin
    reset = 1'b1; zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; opcode = 7'd0;
    do_reset();
    // Directed scenarios
    do_instr(7'b0110011, 1'b0, 0, 0, 1'b0, -1, 3);
    do_instr(7'b0000011, 1'b0, 2, 3, 1'b0, -1, 3);
    do_instr(7'b1100011, 1'b1, 0, 0, 1'b0, -1, 3);
    do_instr(7'b1100011, 1'b0, 1, 0, 1'b0, -1, 3);
    do_instr(7'b0010011, 1'b1, 0, 0, 1'b0, -1, 3);
    do_instr(7'b0100011, 1'b0, 0, WL, 1'b0, -1, 3);
    do_instr(7'b0100011, 1'b0, 0, WL + 1, 1'b0, -1, 20);
    do_instr(7'b1111111, 1'b0, 0, 0, 1'b0, -1, 20);
    do_instr(7'b0110011, 1'b0, WL, 0, 1'b0, -1, 3);
    do_instr(7'b0110011, 1'b0, WL + 1, 0, 1'b0, -1, 5);
    do_instr(7'b1100011, 1'b1, 1, 0, 1'b1, -1, 3);
    do_instr(7'b0110011, 1'b0, 0, 0, 1'b0, -1, 3);
    do_instr(7'b0000011, 1'b0, 0, 6, 1'b0, 2, 3);
    do_instr(7'b0000011, 1'b0, 0, WL, 1'b0, -1, 3);
    // Randomized instruction stream
    for (int i = 0; i < 60; i++) begin
      logic [6:0] op;
      int f, m, r;
      if ($urandom_range(0, 9) == 0) op = rop();
      else op = legal_ops[$urandom_range(0, 4)];
      r = $urandom_range(0, 19);
      f = (r == 0) ? WL + 1 : (r == 1) ? WL : $urandom_range(0, 3);
      r = $urandom_range(0, 19);
      m = (r == 0) ? WL + 1 : (r == 1) ? WL : $urandom_range(0, 4);
      do_instr(op, rb(), f, m, 1'b0, -1, $urandom_range(2, 5));
    end
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clock);
    @(negedge clock);
    if (exp_q.size() > 0) begin
      checks++;
      $display("[TB] FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
